scroll_scan_ctrl: RTL and testbench
===================================

SCROLL_SCAN_CTRL -- requirements
Module: scroll_scan_ctrl

Interface
REQ-001 SHALL have parameter MSG_LEN, default 16, message length in characters (legal 8..16).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth on each level input (legal 2..3).
REQ-003 SHALL have port clk  input  1  100MHz system clock; the only clock, all flops on posedge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port scroll_lvl  input  1  4Hz square wave from clock divider; rising edge = one scroll step.
REQ-006 SHALL have port scan_lvl  input  1  1kHz square wave from clock divider; rising edge = one digit advance.
REQ-007 SHALL have port pause  input  1  high holds scroll offset.
REQ-008 SHALL have port dir  input  1  scroll direction, 0 = forward, 1 = reverse (see REQ-027).
REQ-009 SHALL have port wr_en  input  1  message write strobe, one char per cycle.
REQ-010 SHALL have port wr_addr  input  4  message character index.
REQ-011 SHALL have port wr_data  input  5  character code.
REQ-012 SHALL have port an  output  8  digit enables, active-high, one-hot or zero.
REQ-013 SHALL have port seg  output  8  segments {dp,g,f,e,d,c,b,a}, active-high.
REQ-014 SHALL have port offset  output  4  current scroll offset, for debug.

Function
REQ-015 SHALL pass each level input through SYNC_STAGES flops plus one history flop; tick = synced & ~history, high exactly one clk cycle per rising edge.
REQ-016 SHALL hold a MSG_LEN x 5-bit message buffer; wr_en with wr_addr < MSG_LEN writes wr_data at that posedge; wr_addr >= MSG_LEN is ignored.
REQ-017 SHALL keep digit index idx (3 bits) advancing 0..7 by one per scan tick, wrapping 7 -> 0.
REQ-018 SHALL keep offset advancing by one per scroll tick when pause = 0, wrapping MSG_LEN-1 -> 0; pause = 1 holds offset, and the tick is dropped, not queued.
REQ-019 SHALL register an and seg on the same edge that idx updates: an = 1 << idx_new; seg = decode(buf[(offset_new + idx_new) mod MSG_LEN]).
REQ-020 SHALL also refresh seg (an unchanged) on the edge after any offset change or buffer write, so the display updates within 1 cycle without waiting for a scan tick.
REQ-021 SHALL, when a write and a refresh hit the same location in the same cycle, output the old value that cycle and the new value on the next cycle.
REQ-022 SHALL, on simultaneous scan and scroll ticks, apply both in the same cycle, using new idx and new offset.
REQ-023 SHALL decode codes 0-15 as hex: 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71; code 16 as blank 00; code 17 as dash 40; codes 18-31 as blank 00; dp is always 0.
REQ-024 SHALL compute the address as (offset+idx) with 5-bit sum, subtracting MSG_LEN once if the sum >= MSG_LEN.

Reset
REQ-025 SHALL, while rst_n = 0 at posedge, clear an to 00, seg to 00, idx to 0, offset to 0, and all synchronizer and history flops to 0; buffer location i SHALL be set to code i (i = 0..MSG_LEN-1).
REQ-026 SHALL, when reset is asserted mid-operation, discard pending ticks; the first scan tick after release SHALL drive an = 01.

Configuration
REQ-027 SHALL honour dir only when SCROLL_DIR_EN is defined: dir = 1 decrements offset, wrapping 0 -> MSG_LEN-1. Without the macro, dir SHALL be ignored and offset SHALL always increment; the port remains present.

Verification
REQ-028 Reset, then 8 scan edges -> an steps 01,02,...,80; seg steps 3F,06,5B,4F,66,6D,7D,07.
REQ-029 Scroll edge with offset 15, MSG_LEN 16 -> offset 0; with idx 0, seg shows buf[0] = 3F within 1 cycle.
REQ-030 pause = 1 across 3 scroll edges -> offset unchanged; release, then 1 edge -> offset +1.
REQ-031 Write addr 3 = 17 while idx 3 and offset 0 -> seg 4F that cycle, then 40 on the next cycle; wr_addr 15 with MSG_LEN 12 -> buffer unchanged.
REQ-032 With SCROLL_DIR_EN defined, dir = 1 and offset 0, scroll edge -> offset 15; without the macro, the same stimulus -> offset 1.
REQ-033 rst_n low for 1 cycle mid-scan at idx 5 -> an = 00, offset = 0; next scan edge -> an = 01.

Source files
------------

// File: rtl/scroll_scan_ctrl_if.sv
// Bus bundle for scroll_scan_ctrl: divider levels, scroll controls, message
// write port and the display/debug outputs.
interface scroll_scan_ctrl_if;
    logic       scroll_lvl;
    logic       scan_lvl;
    logic       pause;
    logic       dir;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [4:0] wr_data;
    logic [7:0] an;
    logic [7:0] seg;
    logic [3:0] offset;

    modport master (
        output scroll_lvl, scan_lvl, pause, dir, wr_en, wr_addr, wr_data,
        input  an, seg, offset
    );

    modport slave (
        input  scroll_lvl, scan_lvl, pause, dir, wr_en, wr_addr, wr_data,
        output an, seg, offset
    );
endinterface

// File: rtl/scroll_scan_ctrl.sv
// Scrolling 8-digit 7-segment message controller with a writable buffer.
// Optional macro SCROLL_DIR_EN lets dir = 1 scroll the message in reverse.
module scroll_scan_ctrl #(
    parameter int MSG_LEN     = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    scroll_scan_ctrl_if.slave bus
);
    localparam logic [4:0] LEN5 = 5'(MSG_LEN);
    localparam logic [3:0] LAST = 4'(MSG_LEN - 1);

    logic [SYNC_STAGES-1:0] scroll_sync_q;
    logic [SYNC_STAGES-1:0] scan_sync_q;
    logic                   scroll_hist_q;
    logic                   scan_hist_q;
    logic [4:0]             buf_q [MSG_LEN];
    logic [2:0]             idx_q;
    logic [3:0]             offset_q;
    logic [7:0]             an_q;
    logic [7:0]             seg_q;
    logic                   wr_pend_q;

    logic       scroll_tick_s;
    logic       scan_tick_s;
    logic       step_s;
    logic       wr_ok_s;
    logic       refresh_s;
    logic [2:0] idx_d;
    logic [3:0] offset_d;
    logic [7:0] an_d;
    logic [7:0] seg_d;
    logic [4:0] sum_s;
    logic [3:0] addr_s;

    function automatic logic [7:0] seg_decode(input logic [4:0] code);
        logic [7:0] pat;
        case (code)
            5'd0:    pat = 8'h3F;
            5'd1:    pat = 8'h06;
            5'd2:    pat = 8'h5B;
            5'd3:    pat = 8'h4F;
            5'd4:    pat = 8'h66;
            5'd5:    pat = 8'h6D;
            5'd6:    pat = 8'h7D;
            5'd7:    pat = 8'h07;
            5'd8:    pat = 8'h7F;
            5'd9:    pat = 8'h6F;
            5'd10:   pat = 8'h77;
            5'd11:   pat = 8'h7C;
            5'd12:   pat = 8'h39;
            5'd13:   pat = 8'h5E;
            5'd14:   pat = 8'h79;
            5'd15:   pat = 8'h71;
            5'd17:   pat = 8'h40;
            default: pat = 8'h00;
        endcase
        return pat;
    endfunction

    // Tick detection and write qualification.
    always_comb begin
        scroll_tick_s = scroll_sync_q[SYNC_STAGES-1] & ~scroll_hist_q;
        scan_tick_s   = scan_sync_q[SYNC_STAGES-1] & ~scan_hist_q;
        step_s        = scroll_tick_s & ~bus.pause;
        wr_ok_s       = bus.wr_en & ({1'b0, bus.wr_addr} < LEN5);
    end

    // Next scroll offset; a paused tick is simply lost.
    always_comb begin
        offset_d = offset_q;
        if (step_s) begin
`ifdef SCROLL_DIR_EN
            if (bus.dir) begin
                offset_d = (offset_q == 4'd0) ? LAST : offset_q - 4'd1;
            end else begin
                offset_d = (offset_q == LAST) ? 4'd0 : offset_q + 4'd1;
            end
`else
            offset_d = (offset_q == LAST) ? 4'd0 : offset_q + 4'd1;
`endif
        end else begin
            offset_d = offset_q;
        end
    end

`ifndef SCROLL_DIR_EN
    logic unused_dir_s;
    assign unused_dir_s = bus.dir;
`endif

    // Digit index and display outputs; a dark display (an = 0) lights digit 0
    // first so the scan always starts at the leftmost position after reset.
    always_comb begin
        idx_d = idx_q;
        if (scan_tick_s) begin
            if (an_q == 8'h00) begin
                idx_d = 3'd0;
            end else begin
                idx_d = idx_q + 3'd1;
            end
        end else begin
            idx_d = idx_q;
        end

        sum_s = {1'b0, offset_d} + {2'b00, idx_d};
        if (sum_s >= LEN5) begin
            addr_s = 4'(sum_s - LEN5);
        end else begin
            addr_s = sum_s[3:0];
        end

        refresh_s = scan_tick_s | step_s | wr_pend_q;
        an_d      = scan_tick_s ? (8'd1 << idx_d) : an_q;
        seg_d     = refresh_s ? seg_decode(buf_q[addr_s]) : seg_q;
    end

    // State registers; the buffer reads old data on a same-cycle write and
    // wr_pend_q re-reads it on the following edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scroll_sync_q <= {SYNC_STAGES{1'b0}};
            scan_sync_q   <= {SYNC_STAGES{1'b0}};
            scroll_hist_q <= 1'b0;
            scan_hist_q   <= 1'b0;
            idx_q         <= 3'd0;
            offset_q      <= 4'd0;
            an_q          <= 8'h00;
            seg_q         <= 8'h00;
            wr_pend_q     <= 1'b0;
            for (int i = 0; i < MSG_LEN; i++) begin
                buf_q[i] <= 5'(i);
            end
        end else begin
            scroll_sync_q <= {scroll_sync_q[SYNC_STAGES-2:0], bus.scroll_lvl};
            scan_sync_q   <= {scan_sync_q[SYNC_STAGES-2:0], bus.scan_lvl};
            scroll_hist_q <= scroll_sync_q[SYNC_STAGES-1];
            scan_hist_q   <= scan_sync_q[SYNC_STAGES-1];
            idx_q         <= idx_d;
            offset_q      <= offset_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            wr_pend_q     <= wr_ok_s;
            if (wr_ok_s) begin
                buf_q[bus.wr_addr] <= bus.wr_data;
            end
        end
    end

    assign bus.an     = an_q;
    assign bus.seg    = seg_q;
    assign bus.offset = offset_q;
endmodule

// File: tb/tb_scroll_scan_ctrl.sv
// Self-checking bench for scroll_scan_ctrl: two instances (16/2 and 12/3)
// share stimulus and are compared every cycle against a behavioural model.
module tb_scroll_scan_ctrl;
    localparam int L16 = 16;
    localparam int S16 = 2;
    localparam int L12 = 12;
    localparam int S12 = 3;
`ifdef SCROLL_DIR_EN
    localparam bit DIR_EN = 1'b1;
`else
    localparam bit DIR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scroll_lvl;
    logic       scan_lvl;
    logic       pause;
    logic       dir;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [4:0] wr_data;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    scroll_scan_ctrl_if if16 ();
    scroll_scan_ctrl_if if12 ();

    assign if16.scroll_lvl = scroll_lvl;
    assign if16.scan_lvl   = scan_lvl;
    assign if16.pause      = pause;
    assign if16.dir        = dir;
    assign if16.wr_en      = wr_en;
    assign if16.wr_addr    = wr_addr;
    assign if16.wr_data    = wr_data;
    assign if12.scroll_lvl = scroll_lvl;
    assign if12.scan_lvl   = scan_lvl;
    assign if12.pause      = pause;
    assign if12.dir        = dir;
    assign if12.wr_en      = wr_en;
    assign if12.wr_addr    = wr_addr;
    assign if12.wr_data    = wr_data;

    scroll_scan_ctrl #(.MSG_LEN(L16), .SYNC_STAGES(S16)) dut16 (
        .clk(clk), .rst_n(rst_n), .bus(if16)
    );
    scroll_scan_ctrl #(.MSG_LEN(L12), .SYNC_STAGES(S12)) dut12 (
        .clk(clk), .rst_n(rst_n), .bus(if12)
    );

    // Model state, one slot per instance.
    int seg_tbl [32];
    int m_buf   [2][16];
    int m_idx   [2];
    int m_off   [2];
    int m_an    [2];
    int m_seg   [2];
    bit m_pend  [2];
    bit h_scan  [2][4];
    bit h_scroll[2][4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // A level rise is seen as a tick once it has travelled through the
    // synchronizer delay line; the tick acts on the following edge.
    task automatic model_step(input int k, input int len, input int stages);
        bit scan_tick;
        bit scroll_tick;
        bit step;
        bit refresh;
        if (!rst_n) begin
            m_idx[k]  = 0;
            m_off[k]  = 0;
            m_an[k]   = 0;
            m_seg[k]  = 0;
            m_pend[k] = 1'b0;
            for (int i = 0; i < 16; i++) m_buf[k][i] = i;
            for (int j = 0; j < 4; j++) begin
                h_scan[k][j]   = 1'b0;
                h_scroll[k][j] = 1'b0;
            end
        end else begin
            scan_tick   = h_scan[k][stages-1] && !h_scan[k][stages];
            scroll_tick = h_scroll[k][stages-1] && !h_scroll[k][stages];
            step        = scroll_tick && !pause;
            if (step) begin
                if (DIR_EN && dir) m_off[k] = (m_off[k] + len - 1) % len;
                else               m_off[k] = (m_off[k] + 1) % len;
            end
            if (scan_tick) begin
                if (m_an[k] == 0) m_idx[k] = 0;
                else              m_idx[k] = (m_idx[k] + 1) % 8;
                m_an[k] = 1 << m_idx[k];
            end
            refresh = scan_tick || step || m_pend[k];
            if (refresh) m_seg[k] = seg_tbl[m_buf[k][(m_off[k] + m_idx[k]) % len]];
            m_pend[k] = wr_en && (int'(wr_addr) < len);
            if (m_pend[k]) m_buf[k][wr_addr] = int'(wr_data);
            for (int j = 3; j > 0; j--) begin
                h_scan[k][j]   = h_scan[k][j-1];
                h_scroll[k][j] = h_scroll[k][j-1];
            end
            h_scan[k][0]   = scan_lvl;
            h_scroll[k][0] = scroll_lvl;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step(0, L16, S16);
        model_step(1, L12, S12);
        #1;
        check("an16",  32'(if16.an),     32'(m_an[0]));
        check("seg16", 32'(if16.seg),    32'(m_seg[0]));
        check("off16", 32'(if16.offset), 32'(m_off[0]));
        check("an12",  32'(if12.an),     32'(m_an[1]));
        check("seg12", 32'(if12.seg),    32'(m_seg[1]));
        check("off12", 32'(if12.offset), 32'(m_off[1]));
        @(negedge clk);
    endtask

    task automatic scan_edge();
        scan_lvl = 1'b1;
        repeat (5) cycle();
        scan_lvl = 1'b0;
        repeat (5) cycle();
    endtask

    task automatic scroll_edge();
        scroll_lvl = 1'b1;
        repeat (5) cycle();
        scroll_lvl = 1'b0;
        repeat (5) cycle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        cycle();
    endtask

    logic [7:0] walk_seg [8];
    logic [7:0] hex16    [16];

    initial begin
        walk_seg = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07};
        hex16    = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                     8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
        for (int i = 0; i < 32; i++) seg_tbl[i] = 0;
        for (int i = 0; i < 16; i++) seg_tbl[i] = int'(hex16[i]);
        seg_tbl[17] = 32'h40;

        rst_n      = 1'b0;
        scroll_lvl = 1'b0;
        scan_lvl   = 1'b0;
        pause      = 1'b0;
        dir        = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = 4'd0;
        wr_data    = 5'd0;
        @(negedge clk);
        repeat (2) cycle();
        check("rst_an",  32'(if16.an),     32'h00);
        check("rst_seg", 32'(if16.seg),    32'h00);
        check("rst_off", 32'(if16.offset), 32'h0);
        rst_n = 1'b1;
        cycle();

        // Scan walk across all eight digits from reset.
        for (int i = 0; i < 8; i++) begin
            scan_edge();
            check("walk_an",  32'(if16.an),  32'h1 << i);
            check("walk_seg", 32'(if16.seg), 32'(walk_seg[i]));
        end
        scan_edge();
        check("wrap_an", 32'(if16.an), 32'h01);

        // Offset wrap 15 -> 0 with idx 0.
        repeat (15) scroll_edge();
        check("off15",     32'(if16.offset), 32'd15);
        check("off15_seg", 32'(if16.seg),    32'h71);
        scroll_edge();
        check("offwrap",     32'(if16.offset), 32'd0);
        check("offwrap_seg", 32'(if16.seg),    32'h3F);

        // Pause drops scroll ticks.
        pause = 1'b1;
        repeat (3) scroll_edge();
        check("pause_hold", 32'(if16.offset), 32'd0);
        pause = 1'b0;
        scroll_edge();
        check("pause_rel", 32'(if16.offset), 32'd1);

        // Direction input.
        do_reset();
        dir = 1'b1;
        scroll_edge();
        check("dir_off", 32'(if16.offset), DIR_EN ? 32'd15 : 32'd1);
        dir = 1'b0;

        // Write hitting the displayed digit: old value, then new value.
        do_reset();
        repeat (4) scan_edge();
        check("wr_pre_an",  32'(if16.an),  32'h08);
        check("wr_pre_seg", 32'(if16.seg), 32'h4F);
        wr_en   = 1'b1;
        wr_addr = 4'd3;
        wr_data = 5'd17;
        cycle();
        check("wr_old", 32'(if16.seg), 32'h4F);
        wr_en = 1'b0;
        cycle();
        check("wr_new",   32'(if16.seg), 32'h40);
        check("wr_new12", 32'(if12.seg), 32'h40);
        wr_en   = 1'b1;
        wr_addr = 4'd15;
        wr_data = 5'd0;
        cycle();
        wr_en = 1'b0;
        repeat (2) cycle();
        check("wr_oob12", 32'(if12.seg), 32'h40);

        // Reset in the middle of a scan.
        repeat (2) scan_edge();
        check("mid_an", 32'(if16.an), 32'h20);
        rst_n = 1'b0;
        cycle();
        check("mid_rst_an",  32'(if16.an),     32'h00);
        check("mid_rst_off", 32'(if16.offset), 32'd0);
        rst_n = 1'b1;
        scan_edge();
        check("mid_first_an", 32'(if16.an), 32'h01);

        // Randomized operation.
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 499) != 0);
            if ($urandom_range(0, 5) == 0)  scan_lvl   = ~scan_lvl;
            if ($urandom_range(0, 7) == 0)  scroll_lvl = ~scroll_lvl;
            if ($urandom_range(0, 15) == 0) pause      = ~pause;
            if ($urandom_range(0, 15) == 0) dir        = ~dir;
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_addr = 4'($urandom_range(0, 15));
            wr_data = 5'($urandom_range(0, 31));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
